// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing one RAM/IO port between instruction fetch and load/store.
// Multi-byte accesses are split into byte cycles and reassembled little-endian.
module mem_arbiter #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 32'h0003_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic [31:0]           if_data,
    input  logic                  flush,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [1:0]            ls_size,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_ack,
    output logic [31:0]           ls_rdata,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    typedef enum logic {PORT_IF, PORT_LS} port_t;

    state_t                state, state_d;
    port_t                 last_grant, last_grant_d, owner, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            nbytes, nbytes_d, cnt, cnt_d;
    logic [31:0]           wdata_q, wdata_d, rbuf, rbuf_d;

    logic [ADDR_WIDTH-1:0] mem_a_d;
    logic                  mem_wr_d, if_ack_d, ls_ack_d;
    logic [7:0]            mem_dout_d;
    logic [31:0]           if_data_d, ls_rdata_d;

    logic                  if_valid, ls_valid, grant_ls, grant_if;
    logic                  abort, last_step, stall;
    logic [ADDR_WIDTH-1:0] byte_addr;
    logic [1:0]            rd_idx;
    logic [2:0]            ls_nbytes;

    // A port whose ack is currently high is still seeing its old request.
    assign if_valid  = if_req && !if_ack && !flush;
    assign ls_valid  = ls_req && !ls_ack;
    assign grant_ls  = ls_valid && (!if_valid || last_grant == PORT_IF);
    assign grant_if  = if_valid && !grant_ls;

    assign byte_addr = addr_q + ADDR_WIDTH'(cnt);
    assign last_step = (cnt == nbytes);
    assign abort     = (state == READ) && (owner == PORT_IF) && flush;
    assign stall     = (byte_addr >= IO_BASE) && io_buffer_full;
    assign rd_idx    = cnt[1:0] - 2'd1;

    always_comb begin
        unique case (ls_size)
            2'b00:   ls_nbytes = 3'd1;
            2'b01:   ls_nbytes = 3'd2;
            default: ls_nbytes = 3'd4;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (grant_ls)      state_d = ls_we ? WRITE : READ;
                else if (grant_if) state_d = READ;
            end
            READ:    if (abort || last_step) state_d = IDLE;
            WRITE:   if (last_step)          state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every signal gets a default first so no path through the case
    // statement leaves a value unassigned, which would infer a latch.
    always_comb begin
        last_grant_d = last_grant;
        owner_d      = owner;
        addr_d       = addr_q;
        nbytes_d     = nbytes;
        wdata_d      = wdata_q;
        rbuf_d       = rbuf;
        cnt_d        = cnt;
        mem_a_d      = '0;
        mem_wr_d     = 1'b0;
        mem_dout_d   = mem_dout;
        if_ack_d     = 1'b0;
        ls_ack_d     = 1'b0;
        if_data_d    = if_data;
        ls_rdata_d   = ls_rdata;

        unique case (state)
            IDLE: begin
                if (grant_ls) begin
                    last_grant_d = PORT_LS;
                    owner_d      = PORT_LS;
                    addr_d       = ls_addr;
                    nbytes_d     = ls_nbytes;
                    wdata_d      = ls_wdata;
                    rbuf_d       = '0;
                    cnt_d        = '0;
                end else if (grant_if) begin
                    last_grant_d = PORT_IF;
                    owner_d      = PORT_IF;
                    addr_d       = if_addr;
                    nbytes_d     = 3'd4;
                    rbuf_d       = '0;
                    cnt_d        = '0;
                end
            end
            READ: begin
                if (abort) begin
                    cnt_d = '0;
                end else begin
                    if (!last_step) mem_a_d = byte_addr;
                    // The byte addressed on the previous edge is on mem_din now.
                    if (cnt != 3'd0) rbuf_d[{rd_idx, 3'b000} +: 8] = mem_din;
                    if (last_step) begin
                        cnt_d = '0;
                        if (owner == PORT_IF) begin
                            if_ack_d  = 1'b1;
                            if_data_d = rbuf_d;
                        end else begin
                            ls_ack_d   = 1'b1;
                            ls_rdata_d = rbuf_d;
                        end
                    end else begin
                        cnt_d = cnt + 3'd1;
                    end
                end
            end
            WRITE: begin
                if (last_step) begin
                    ls_ack_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    mem_a_d = byte_addr;
                    if (!stall) begin
                        mem_wr_d   = 1'b1;
                        mem_dout_d = wdata_q[{cnt[1:0], 3'b000} +: 8];
                        cnt_d      = cnt + 3'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT_IF;
            owner      <= PORT_IF;
            addr_q     <= '0;
            nbytes     <= '0;
            wdata_q    <= '0;
            rbuf       <= '0;
            cnt        <= '0;
            mem_a      <= '0;
            mem_wr     <= 1'b0;
            mem_dout   <= '0;
            if_ack     <= 1'b0;
            ls_ack     <= 1'b0;
            if_data    <= '0;
            ls_rdata   <= '0;
        end else begin
            last_grant <= last_grant_d;
            owner      <= owner_d;
            addr_q     <= addr_d;
            nbytes     <= nbytes_d;
            wdata_q    <= wdata_d;
            rbuf       <= rbuf_d;
            cnt        <= cnt_d;
            mem_a      <= mem_a_d;
            mem_wr     <= mem_wr_d;
            mem_dout   <= mem_dout_d;
            if_ack     <= if_ack_d;
            ls_ack     <= ls_ack_d;
            if_data    <= if_data_d;
            ls_rdata   <= ls_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: LS transfer table plus stall, arbitration,
// flush and reset sequences against a byte-wide RAM model.
module tb_mem_arbiter;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0, flush = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
    logic [AW-1:0] if_addr = '0, ls_addr = '0;
    logic [1:0]    ls_size = '0;
    logic [31:0]   ls_wdata = '0;
    logic          io_buffer_full = 1'b0;
    logic          if_ack, ls_ack, mem_wr;
    logic [31:0]   if_data, ls_rdata;
    logic [7:0]    mem_din, mem_dout;
    logic [AW-1:0] mem_a;

    mem_arbiter #(.ADDR_WIDTH(AW), .IO_BASE(32'h0003_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
        .flush(flush),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_size(ls_size),
        .ls_wdata(ls_wdata), .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h11;
            32'h101: return 8'h22;
            32'h102: return 8'h33;
            32'h103: return 8'h44;
            default: return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    assign mem_din = ram_byte(mem_a);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic run_vec(input vec_t v);
        int          nb, cyc, bad, wr_total;
        logic        got;
        logic [31:0] ra [0:31];
        logic        rw [0:31];
        logic [7:0]  rd [0:31];
        nb = (v.size == 2'b00) ? 1 : (v.size == 2'b01) ? 2 : 4;
        ls_we = v.we; ls_addr = v.addr; ls_size = v.size; ls_wdata = v.wdata;
        ls_req = 1'b1;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 30) begin
            @(negedge clk);
            cyc++;
            ra[cyc] = mem_a; rw[cyc] = mem_wr; rd[cyc] = mem_dout;
            got = ls_ack;
        end
        ls_req = 1'b0;
        check({v.name, " ack"}, {31'd0, got}, 32'd1);
        check({v.name, " latency"}, 32'(cyc - 1), 32'(nb + 1));
        if (!v.we) check({v.name, " rdata"}, ls_rdata, v.rdata);
        bad = 0; wr_total = 0;
        for (int i = 1; i <= cyc; i++) if (rw[i]) wr_total++;
        for (int i = 1; i <= nb; i++) begin
            if (i + 1 > cyc) bad++;
            else begin
                if (ra[i+1] !== v.addr + 32'(i - 1)) bad++;
                if (rw[i+1] !== v.we) bad++;
                if (v.we && rd[i+1] !== v.wdata[8*(i-1) +: 8]) bad++;
            end
        end
        check({v.name, " bus sequence errors"}, 32'(bad), 32'd0);
        check({v.name, " write strobes"}, 32'(wr_total), v.we ? 32'(nb) : 32'd0);
    endtask

    initial begin
        int          n, cyc;
        logic        order [4];
        logic [31:0] ls_d, if_d;
        logic        seen_if, seen_ls, seen_wr;

        vecs[0] = '{"ld word 0x100",   1'b0, 32'h0000_0100, 2'b10, 32'h0,         32'h4433_2211};
        vecs[1] = '{"ld byte 0x103",   1'b0, 32'h0000_0103, 2'b00, 32'h0,         32'h0000_0044};
        vecs[2] = '{"ld half 0x101",   1'b0, 32'h0000_0101, 2'b01, 32'h0,         32'h0000_3322};
        vecs[3] = '{"ld size11 0x100", 1'b0, 32'h0000_0100, 2'b11, 32'h0,         32'h4433_2211};
        vecs[4] = '{"st word 0x400",   1'b1, 32'h0000_0400, 2'b10, 32'hDEAD_BEEF, 32'h0};
        vecs[5] = '{"st half 0x501",   1'b1, 32'h0000_0501, 2'b01, 32'h1234_ABCD, 32'h0};
        vecs[6] = '{"ld half wrap",    1'b0, 32'hFFFF_FFFF, 2'b01, 32'h0,         32'h0000_5AA5};
        vecs[7] = '{"st byte io",      1'b1, 32'h0003_0000, 2'b00, 32'h0000_01AB, 32'h0};

        repeat (3) @(negedge clk);
        check("reset mem_a", mem_a, 32'h0);
        check("reset mem_wr", {31'd0, mem_wr}, 32'h0);
        check("reset mem_dout", {24'd0, mem_dout}, 32'h0);
        check("reset acks", {30'd0, if_ack, ls_ack}, 32'h0);
        check("reset if_data", if_data, 32'h0);
        check("reset ls_rdata", ls_rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
            @(negedge clk);
        end

        // IO store held off by a full UART buffer for three edges.
        ls_we = 1'b1; ls_addr = 32'h0003_0000; ls_size = 2'b00; ls_wdata = 32'h0000_01AB;
        io_buffer_full = 1'b1; ls_req = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("io stall mem_wr", {31'd0, mem_wr}, 32'h0);
            check("io stall ls_ack", {31'd0, ls_ack}, 32'h0);
        end
        io_buffer_full = 1'b0;
        @(negedge clk);
        check("io issue mem_wr", {31'd0, mem_wr}, 32'h1);
        check("io issue mem_a", mem_a, 32'h0003_0000);
        check("io issue mem_dout", {24'd0, mem_dout}, 32'h0000_00AB);
        @(negedge clk);
        check("io ack", {31'd0, ls_ack}, 32'h1);
        check("io ack mem_wr", {31'd0, mem_wr}, 32'h0);
        ls_req = 1'b0;
        @(negedge clk);

        // Both ports pending continuously from reset: LS first, then alternate.
        rst_n = 1'b0;
        if_req = 1'b1; if_addr = 32'h0000_0200;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0100; ls_size = 2'b10;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0; ls_d = '0; if_d = '0;
        for (int c = 0; c < 80 && n < 4; c++) begin
            @(negedge clk);
            if (ls_ack) begin
                if (n == 0) ls_d = ls_rdata;
                order[n] = 1'b0; n++;
            end else if (if_ack) begin
                if (n == 1) if_d = if_data;
                order[n] = 1'b1; n++;
            end
        end
        if_req = 1'b0; ls_req = 1'b0;
        check("arb ack count", 32'(n), 32'd4);
        for (int i = 0; i < n; i++) check($sformatf("arb order %0d (0=LS)", i), {31'd0, order[i]}, 32'(i % 2));
        check("arb first ls_rdata", ls_d, 32'h4433_2211);
        check("arb first if_data", if_d, 32'h5958_5B5A);
        @(negedge clk);

        // Flush two cycles into a fetch; the waiting LS load goes next.
        if_req = 1'b1; if_addr = 32'h0000_0210;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1; if_req = 1'b0;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0100; ls_size = 2'b10;
        @(negedge clk);
        flush = 1'b0;
        check("flush no if_ack", {31'd0, if_ack}, 32'h0);
        check("flush mem_a idle", mem_a, 32'h0);
        cyc = 0; seen_if = 1'b0; seen_ls = 1'b0;
        while (!seen_ls && cyc < 20) begin
            @(negedge clk);
            cyc++;
            seen_ls = ls_ack;
            if (if_ack) seen_if = 1'b1;
        end
        ls_req = 1'b0;
        check("flush ls latency", 32'(cyc), 32'd6);
        check("flush ls_rdata", ls_rdata, 32'h4433_2211);
        check("flush if_ack never", {31'd0, seen_if}, 32'h0);
        check("flush if_data kept", if_data, 32'h5958_5B5A);
        @(negedge clk);

        // Reset asserted while byte 2 of a word store is on the bus.
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_0600; ls_size = 2'b10;
        ls_wdata = 32'h1122_3344;
        repeat (4) @(negedge clk);
        check("rst mid byte2 mem_wr", {31'd0, mem_wr}, 32'h1);
        check("rst mid byte2 mem_a", mem_a, 32'h0000_0602);
        check("rst mid byte2 dout", {24'd0, mem_dout}, 32'h0000_0022);
        #1 rst_n = 1'b0;
        #1;
        check("rst async mem_wr", {31'd0, mem_wr}, 32'h0);
        check("rst async acks", {30'd0, if_ack, ls_ack}, 32'h0);
        check("rst async mem_a", mem_a, 32'h0);
        ls_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_ls = 1'b0; seen_wr = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ls_ack || if_ack) seen_ls = 1'b1;
            if (mem_wr) seen_wr = 1'b1;
        end
        check("rst no ack after release", {31'd0, seen_ls}, 32'h0);
        check("rst no write after release", {31'd0, seen_wr}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-wide RAM/IO port of riscv_top between two requesters: instruction fetch (IF) and load/store unit (LS).
- Serialises each 1/2/4-byte access into byte cycles, assembles read data little-endian, and returns a one-cycle ack.
- Stalls IO-mapped writes while the UART buffer is full.
- Supports aborting an in-flight instruction fetch on pipeline flush.

Parameters:
- ADDR_WIDTH, 32, width of all address ports.
- IO_BASE, 32'h0003_0000, addresses >= IO_BASE are IO-mapped.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  IF requests a 4-byte read
- if_addr  in  ADDR_WIDTH  IF byte address
- if_ack  out  1  one-cycle pulse; if_data valid this cycle
- if_data  out  32  fetched word
- flush  in  1  abort pending/in-flight IF access
- ls_req  in  1  LS request
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_WIDTH  LS byte address
- ls_size  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal and treated as word
- ls_wdata  in  32  store data; low bytes used
- ls_ack  out  1  one-cycle pulse; ls_rdata valid for loads
- ls_rdata  out  32  load data, zero-extended
- mem_din  in  8  RAM/IO read byte; valid one cycle after mem_a
- mem_dout  out  8  write byte
- mem_a  out  ADDR_WIDTH  memory byte address
- mem_wr  out  1  write strobe
- io_buffer_full  in  1  UART TX buffer full

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_a=0, mem_wr=0, mem_dout=0, if_ack=0, ls_ack=0, if_data=0, ls_rdata=0, byte counter=0, last_grant=IF.
- All outputs are registered.
- States: IDLE, READ, WRITE.
- Request masking: a port's req is ignored in any cycle where that port's ack is high. if_req is also ignored while flush=1.
- Arbitration in IDLE:
  - One valid request: grant it.
  - Both valid: grant the port that is not last_grant, so LS wins first after reset.
  - Update last_grant on every grant.
  - Latch addr, size (IF is always 4), we and wdata at the grant edge.
- Grant edge = E0. N = 1/2/4 bytes.
- READ:
  - At edges E1..EN drive mem_a = addr+i-1, mem_wr=0.
  - At edges E2..E(N+1) capture mem_din into byte i-2 of the result.
  - At E(N+1): ack=1 with data, mem_a=0, state IDLE. Ack drops at the next edge.
  - Total N+1 cycles from grant to ack.
- WRITE:
  - Each byte i is issued at an edge by driving mem_a = addr+i, mem_dout = wdata[8i+7:8i], mem_wr=1.
  - If addr+i >= IO_BASE and io_buffer_full=1 at that edge, drive mem_wr=0 instead, hold the counter, and retry next edge. Unbounded stall is allowed.
  - The edge after the last byte is issued: mem_wr=0, ls_ack=1, state IDLE.
  - Unstalled store of N bytes: ack at E(N+1).
- Address arithmetic: byte addresses increment modulo 2^ADDR_WIDTH. Wrap is permitted; no alignment is required.
- flush:
  - flush=1 during a granted IF READ: at the next edge return to IDLE, no if_ack, if_data unchanged.
  - flush has no effect on LS transactions or on an if_ack already asserted.
- ls_rdata bits above 8N are 0. The requester performs sign extension.
- mem_wr is never high in READ or IDLE.
- Reset mid-transaction: immediate return to reset values; no ack is produced.

Test Plan:
- LS word load at 0x100, RAM bytes 11,22,33,44 -> mem_a 0x100..0x103 on consecutive cycles, ls_ack 5 cycles after grant, ls_rdata=32'h44332211.
- LS byte store 0x1AB to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for 3 cycles, then one cycle mem_wr=1 with mem_a=0x30000 and mem_dout=8'hAB, ls_ack the following cycle.
- if_req and ls_req both asserted from reset, held until ack -> LS served first, then IF; repeat with both continuously pending -> grants alternate.
- IF fetch at 0x200 with flush=1 two cycles after grant -> no if_ack, arbiter IDLE next cycle, pending ls_req granted immediately after.
- Halfword load at 0xFFFF_FFFF -> mem_a 0xFFFF_FFFF then 0x0000_0000, ls_rdata[31:16]=0.
- rst_n low during a word store, mid-byte 2 -> mem_wr=0 and all acks 0 immediately; no ack after release.
